// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector with a runtime-programmable pattern (1..MAX_LEN bits),
// overlapping or non-overlapping matches, a Mealy match output and a saturating match counter.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1011,
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               y,
    output logic               y_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    // en acts as a bit-valid strobe with no backpressure: x is consumed on every
    // rising edge where en=1 and cfg_load=0; cfg_load takes priority and drops that bit.
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   vcnt;

    logic [LEN_W-1:0]   eff_len;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     vcnt_p1;
    logic               pat_ok;
    logic               hist_ok;
    logic               accept;

    assign eff_len = (len_q > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_q;
    assign cand    = {hist[MAX_LEN-2:0], x};
    assign vcnt_p1 = {1'b0, vcnt} + (LEN_W+1)'(1);

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < eff_len);
        end
    end

    // Only the low L bits of history+current bit take part in the compare.
    assign pat_ok  = (((cand ^ pat_q) & mask) == '0);
    assign hist_ok = (vcnt_p1 >= {1'b0, eff_len});
    assign accept  = en & ~cfg_load;
    assign y       = accept & (eff_len != '0) & hist_ok & pat_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= DEF_PATTERN;
            len_q <= LEN_W'(DEF_LEN);
            ovl_q <= DEF_OVERLAP;
            hist  <= '0;
            vcnt  <= '0;
        end else if (cfg_load) begin
            pat_q <= pattern;
            len_q <= len;
            ovl_q <= overlap;
            vcnt  <= '0;
        end else if (en) begin
            hist <= cand;
            if (y && !ovl_q) begin
                vcnt <= '0;
            end else if (vcnt != LEN_W'(MAX_LEN)) begin
                vcnt <= vcnt + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            y_q <= y;
            if (cnt_clr) begin
                match_cnt <= '0;
                cnt_sat   <= 1'b0;
            end else if (y && !cnt_sat) begin
                match_cnt <= match_cnt + CNT_W'(1);
                cnt_sat   <= ((match_cnt + CNT_W'(1)) == '1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param with a 3-bit counter so saturation is reachable.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               x;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic               cnt_clr;
    logic               y;
    logic               y_q;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic exp_yq    = 1'b0;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W),
        .DEF_PATTERN(8'b0000_1011), .DEF_LEN(4), .DEF_OVERLAP(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
        .pattern(pattern), .len(len), .overlap(overlap), .cnt_clr(cnt_clr),
        .y(y), .y_q(y_q), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One cycle: check y_q from the previous cycle, drive inputs, check Mealy y before the edge.
    task automatic step(input logic e, input logic b, input logic ld, input logic clr,
                        input logic ey, input string tag);
        @(negedge clk);
        chk({tag, "_yq"}, {31'd0, y_q}, {31'd0, exp_yq});
        en = e; x = b; cfg_load = ld; cnt_clr = clr;
        #1 chk({tag, "_y"}, {31'd0, y}, {31'd0, ey});
        exp_yq = ey;
    endtask

    task automatic idle_check(input string tag, input int exp_cnt, input logic exp_sat);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {tag, "_idle"});
        chk({tag, "_cnt"}, {29'd0, match_cnt}, exp_cnt);
        chk({tag, "_sat"}, {31'd0, cnt_sat}, {31'd0, exp_sat});
    endtask

    initial begin
        logic [6:0] s1;
        logic [6:0] e1;
        logic [6:0] e2;
        logic [8:0] s3;
        rst = 1'b1; en = 1'b1; x = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
        pattern = '0; len = '0; overlap = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_y",   {31'd0, y},       32'd0);
        chk("rst_yq",  {31'd0, y_q},     32'd0);
        chk("rst_cnt", {29'd0, match_cnt}, 32'd0);
        chk("rst_sat", {31'd0, cnt_sat}, 32'd0);
        rst = 1'b0;

        // 1: default 1011 overlapping
        s1 = 7'b1011011; e1 = 7'b0001001;
        for (int i = 6; i >= 0; i--) step(1'b1, s1[i], 1'b0, 1'b0, e1[i], "t1");
        idle_check("t1", 2, 1'b0);

        // 2: same pattern non-overlapping
        pattern = 8'b0000_1011; len = 4'd4; overlap = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "t2_load");
        e2 = 7'b0001000;
        for (int i = 6; i >= 0; i--) step(1'b1, s1[i], 1'b0, 1'b0, e2[i], "t2");
        idle_check("t2", 1, 1'b0);

        // 3: full-length pattern with en gaps mid-pattern
        pattern = 8'b1110_0101; len = 4'd8; overlap = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t3_load");
        s3 = 9'b011100101;
        for (int i = 8; i >= 0; i--) begin
            if (i == 4) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t3_gap");
                step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t3_gap");
            end
            step(1'b1, s3[i], 1'b0, 1'b0, (i == 0), "t3");
        end
        idle_check("t3", 1, 1'b0);

        // 4: length 1, then length 0 disables detection
        pattern = 8'b0000_0001; len = 4'd1; overlap = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "t4_load");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "t4");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "t4");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t4");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "t4");
        idle_check("t4", 3, 1'b0);
        pattern = 8'b0000_0000; len = 4'd0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "t4z_load");
        for (int i = 0; i < 6; i++) step(1'b1, i[0], 1'b0, 1'b0, 1'b0, "t4z");
        idle_check("t4z", 0, 1'b0);

        // 5: saturation of the 3-bit counter, then clear wins over a match
        pattern = 8'b0000_0011; len = 4'd2; overlap = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "t5_load");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, (i != 0), "t5");
        idle_check("t5", 7, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "t5_hold");
        idle_check("t5_hold", 7, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "t5_clr");
        idle_check("t5_clr", 0, 1'b0);

        // 6: async reset mid-stream discards partial match and restores defaults
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "t6");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_y",   {31'd0, y},         32'd0);
        chk("t6_rst_yq",  {31'd0, y_q},       32'd0);
        chk("t6_rst_cnt", {29'd0, match_cnt}, 32'd0);
        chk("t6_rst_sat", {31'd0, cnt_sat},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_yq = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6_post");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_post");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6_post");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "t6_post");
        idle_check("t6", 1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
